// File: rtl/mem_arb_fsm.sv
// -----------------------------------------------------------------------------
// mem_arb_fsm
//   Round-robin arbiter in front of a single-port word memory.
//   NUM_CH requesters hold a read or write request until their one-cycle
//   done pulse. Each access is latched on grant. It then spends WAIT_ST
//   cycles in WAIT and one cycle in COMPLETE. At the end of COMPLETE the
//   array write or rdata update happens, and done/err are registered.
//
//   Optional feature: define MEM_ARB_BYTE_MASK_EN to enable per-byte write
//   masking through i_wmask. When undefined, i_wmask is ignored and writes
//   replace the full word.
//
// Ports
//   i_clk     : clock, all state on rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_rd_en   : [NUM_CH] per-channel read request
//   i_wr_en   : [NUM_CH] per-channel write request (read wins if both)
//   i_addr    : [NUM_CH*ADDR_W] per-channel address, channel i at i*ADDR_W
//   i_wdata   : [NUM_CH*DATA_W] per-channel write data
//   i_wmask   : [NUM_CH*DATA_W/8] per-channel byte enables (masking build only)
//   o_rdata   : data of the last completed read (0 for out-of-range reads)
//   o_done    : [NUM_CH] one-cycle completion pulse, at most one bit high
//   o_err     : completed access had address >= DEPTH (valid with o_done)
//   o_busy    : an access is in progress (state not IDLE)
//   o_grant   : channel being served or last served
// -----------------------------------------------------------------------------
module mem_arb_fsm #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4096,
    parameter int NUM_CH  = 2,
    parameter int WAIT_ST = 0,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_CH-1:0]          i_rd_en,
    input  logic [NUM_CH-1:0]          i_wr_en,
    input  logic [NUM_CH*ADDR_W-1:0]   i_addr,
    input  logic [NUM_CH*DATA_W-1:0]   i_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] i_wmask,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [NUM_CH-1:0]          o_done,
    output logic                       o_err,
    output logic                       o_busy,
    output logic [GW-1:0]              o_grant
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WCNT_LAST = 4'((WAIT_ST > 0) ? WAIT_ST - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [GW-1:0]     r_grant;
    logic [3:0]        r_wcnt;
    logic [NUM_CH-1:0] r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_op_rd;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_mem_q;

    logic [ADDR_W-1:0] w_addr_ch  [NUM_CH];
    logic [DATA_W-1:0] w_wdata_ch [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic [GW-1:0]     w_cand;
    logic [GW-1:0]     w_sel;
    logic              w_found;
    logic              w_take;
    logic              w_finish;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_rd_strobe;
    logic              w_wr_strobe;

    // Unpack the per-channel buses.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_addr_ch[gi]  = i_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_ch[gi] = i_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef MEM_ARB_BYTE_MASK_EN
    logic [NB-1:0] r_mask;
    logic [NB-1:0] w_wmask_ch [NUM_CH];
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack_mask
            assign w_wmask_ch[gi] = i_wmask[gi*NB +: NB];
        end
    endgenerate
`else
    logic w_unused_wmask;
    assign w_unused_wmask = ^i_wmask;
`endif

    // A channel whose done is high this cycle is not re-served yet.
    assign w_elig = (i_rd_en | i_wr_en) & ~r_done;

    // Round-robin search starting one past the last grant.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_grant;
        w_cand  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = GW'((32'(r_grant) + 32'(i)) % 32'(NUM_CH));
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    // Next-state logic; grants are only taken from IDLE.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take       = 1'b1;
                    w_state_next = (WAIT_ST > 0) ? WAIT : COMPLETE;
                end
            end
            WAIT: begin
                if (r_wcnt == WCNT_LAST) begin
                    w_state_next = COMPLETE;
                end
            end
            COMPLETE: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_in_range  = ({1'b0, r_addr} < DEPTH_X);
    assign w_idx       = r_addr[IDX_W-1:0];
    // The array is read on the edge that enters COMPLETE. With no wait
    // states that is the grant edge, so the address comes straight from
    // the winning channel.
    assign w_rd_idx    = w_take ? w_addr_ch[w_sel][IDX_W-1:0] : r_addr[IDX_W-1:0];
    assign w_rd_strobe = (w_state_next == COMPLETE);
    // Gated by state, so an access aborted by reset never writes.
    assign w_wr_strobe = w_finish && !r_op_rd && w_in_range;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant <= GW'(NUM_CH - 1);
            r_wcnt  <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op_rd <= 1'b0;
`ifdef MEM_ARB_BYTE_MASK_EN
            r_mask  <= '0;
`endif
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_take) begin
                r_grant <= w_sel;
                r_addr  <= w_addr_ch[w_sel];
                r_wdata <= w_wdata_ch[w_sel];
                r_op_rd <= i_rd_en[w_sel];
                r_wcnt  <= '0;
`ifdef MEM_ARB_BYTE_MASK_EN
                r_mask  <= w_wmask_ch[w_sel];
`endif
            end else if (r_state == WAIT) begin
                r_wcnt <= r_wcnt + 4'd1;
            end
            if (w_finish) begin
                r_done[r_grant] <= 1'b1;
                r_err           <= !w_in_range;
                if (r_op_rd) begin
                    r_rdata <= w_in_range ? r_mem_q : '0;
                end
            end
        end
    end

    // Storage: not reset, registered read port.
    always_ff @(posedge i_clk) begin
        if (w_rd_strobe) begin
            r_mem_q <= r_mem[w_rd_idx];
        end
`ifdef MEM_ARB_BYTE_MASK_EN
        for (int b = 0; b < NB; b++) begin
            if (w_wr_strobe && r_mask[b]) begin
                r_mem[w_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
        end
`else
        if (w_wr_strobe) begin
            r_mem[w_idx] <= r_wdata;
        end
`endif
    end

    assign o_rdata = r_rdata;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_busy  = (r_state != IDLE);
    assign o_grant = r_grant;

endmodule

// File: tb/tb_mem_arb_fsm.sv
// -----------------------------------------------------------------------------
// tb_mem_arb_fsm
//   Three instances: dut0 WAIT_ST=0, dut1 WAIT_ST=3, dut2 WAIT_ST=2. They use
//   NUM_CH=2, DEPTH=4096, DATA_W=ADDR_W=16. A reference model tracks memory
//   words 0..15, the last read value and the last served channel per
//   instance. Every completion is compared with it.
// -----------------------------------------------------------------------------
module tb_mem_arb_fsm;
    localparam int NCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int ND  = 3;
`ifdef MEM_ARB_BYTE_MASK_EN
    localparam logic [15:0] MASK_EXP = 16'hFFAB;
`else
    localparam logic [15:0] MASK_EXP = 16'h00AB;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n [ND];
    logic [NCH-1:0]        rd_en [ND];
    logic [NCH-1:0]        wr_en [ND];
    logic [NCH*AW-1:0]     addr  [ND];
    logic [NCH*DW-1:0]     wdata [ND];
    logic [NCH*DW/8-1:0]   wmask [ND];
    logic [DW-1:0]         rdata [ND];
    logic [NCH-1:0]        done  [ND];
    logic                  err   [ND];
    logic                  busy  [ND];
    logic [0:0]            grant [ND];

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
            mem_arb_fsm #(
                .DATA_W (DW),
                .ADDR_W (AW),
                .DEPTH  (4096),
                .NUM_CH (NCH),
                .WAIT_ST(WS)
            ) u_dut (
                .i_clk   (clk),
                .i_rst_n (rst_n[gi]),
                .i_rd_en (rd_en[gi]),
                .i_wr_en (wr_en[gi]),
                .i_addr  (addr[gi]),
                .i_wdata (wdata[gi]),
                .i_wmask (wmask[gi]),
                .o_rdata (rdata[gi]),
                .o_done  (done[gi]),
                .o_err   (err[gi]),
                .o_busy  (busy[gi]),
                .o_grant (grant[gi])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [15:0] mdl_mem   [ND][16];
    logic [15:0] mdl_rdata [ND];
    int          mdl_last  [ND];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
        end
    endtask

    // One isolated access on channel ch; the DUT is idle on entry.
    task automatic access(input int d, input int ch, input bit rd, input bit wr,
                          input int a, input logic [15:0] wd, input logic [1:0] m);
        int          lat;
        bit          oor;
        logic [15:0] cur;
        lat = 1 + ws_of(d);
        oor = (a >= 4096);
        rd_en[d][ch]             = rd;
        wr_en[d][ch]             = wr;
        addr[d][ch*AW +: AW]     = 16'(a);
        wdata[d][ch*DW +: DW]    = wd;
        wmask[d][ch*2 +: 2]      = m;
        if (rd) begin
            mdl_rdata[d] = oor ? 16'h0000 : mdl_mem[d][a];
        end else if (!oor) begin
            cur = mdl_mem[d][a];
`ifdef MEM_ARB_BYTE_MASK_EN
            if (m[0]) cur[7:0]  = wd[7:0];
            if (m[1]) cur[15:8] = wd[15:8];
`else
            cur = wd;
`endif
            mdl_mem[d][a] = cur;
        end
        for (int n = 1; n <= lat + 1; n++) begin
            @(posedge clk); #1;
            if (n <= lat) begin
                chk("busy_during", d, 32'(busy[d]), 32'd1);
                chk("done_early", d, 32'(done[d]), 32'd0);
            end else begin
                chk("done_pulse", d, 32'(done[d]), (ch == 1) ? 32'd2 : 32'd1);
                chk("busy_after", d, 32'(busy[d]), 32'd0);
                chk("err", d, 32'(err[d]), 32'(oor));
                chk("grant", d, 32'(grant[d]), 32'(ch));
                chk("rdata", d, 32'(rdata[d]), 32'(mdl_rdata[d]));
            end
        end
        rd_en[d][ch] = 1'b0;
        wr_en[d][ch] = 1'b0;
        mdl_last[d]  = ch;
        @(posedge clk); #1;
        chk("done_width", d, 32'(done[d]), 32'd0);
        $display("dut%0d ch%0d %s addr=0x%0h wdata=0x%04h mask=%b rdata=0x%04h err=%0d",
                 d, ch, rd ? "RD" : "WR", a, wd, m, rdata[d], err[d]);
    endtask

    // Both channels hold reads of addresses 3 (ch0) and 9 (ch1).
    task automatic rr(input int d, input int want);
        int got;
        int cyc;
        int exp_ch;
        int last_cyc;
        got      = 0;
        cyc      = 0;
        last_cyc = -1;
        exp_ch   = (mdl_last[d] + 1) % 2;
        addr[d]  = {16'd9, 16'd3};
        wr_en[d] = 2'b00;
        rd_en[d] = 2'b11;
        while (got < want && cyc < want * (3 + ws_of(d)) + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (done[d] != 2'b00) begin
                chk("rr_done", d, 32'(done[d]), (exp_ch == 1) ? 32'd2 : 32'd1);
                chk("rr_grant", d, 32'(grant[d]), 32'(exp_ch));
                chk("rr_err", d, 32'(err[d]), 32'd0);
                chk("rr_rdata", d, 32'(rdata[d]), 32'(mdl_mem[d][(exp_ch == 1) ? 9 : 3]));
                if (last_cyc >= 0) begin
                    chk("rr_gap", d, 32'(cyc - last_cyc), 32'(2 + ws_of(d)));
                end
                $display("dut%0d rr ch%0d rdata=0x%04h cycle=%0d", d, exp_ch, rdata[d], cyc);
                mdl_rdata[d] = mdl_mem[d][(exp_ch == 1) ? 9 : 3];
                mdl_last[d]  = exp_ch;
                last_cyc     = cyc;
                exp_ch       = 1 - exp_ch;
                got++;
            end
        end
        rd_en[d] = 2'b00;
        chk("rr_count", d, 32'(got), 32'(want));
        @(posedge clk); #1;
        chk("rr_quiet", d, 32'(done[d]), 32'd0);
    endtask

    initial begin
        int ch;
        int op;
        int a;

        for (int d = 0; d < ND; d++) begin
            rst_n[d]     = 1'b0;
            rd_en[d]     = '0;
            wr_en[d]     = '0;
            addr[d]      = '0;
            wdata[d]     = '0;
            wmask[d]     = '0;
            mdl_rdata[d] = 16'h0000;
            mdl_last[d]  = 1;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_busy", d, 32'(busy[d]), 32'd0);
            chk("rst_done", d, 32'(done[d]), 32'd0);
            chk("rst_err", d, 32'(err[d]), 32'd0);
            chk("rst_rdata", d, 32'(rdata[d]), 32'd0);
            chk("rst_grant", d, 32'(grant[d]), 32'd1);
            rst_n[d] = 1'b1;
        end

        // Fill the modelled window, then random traffic.
        for (int d = 0; d < ND; d++) begin
            for (int w = 0; w < 16; w++) begin
                access(d, int'($urandom_range(0, 1)), 1'b0, 1'b1, w, 16'($urandom), 2'b11);
            end
            for (int t = 0; t < 25; t++) begin
                ch = int'($urandom_range(0, 1));
                op = int'($urandom_range(0, 2));
                a  = ($urandom_range(0, 7) == 0) ? 4096 + int'($urandom_range(0, 61439))
                                                  : int'($urandom_range(0, 15));
                access(d, ch, op != 1, op != 0, a, 16'($urandom), 2'($urandom_range(0, 3)));
            end
        end

        // Single write then read.
        access(0, 0, 1'b0, 1'b1, 5, 16'hBEEF, 2'b11);
        access(0, 0, 1'b1, 1'b0, 5, 16'h0000, 2'b00);
        chk("beef_readback", 0, 32'(rdata[0]), 32'h0000BEEF);

        // Out of range write and read; address 0 untouched.
        access(0, 1, 1'b0, 1'b1, 4096, 16'h1234, 2'b11);
        access(0, 1, 1'b1, 1'b0, 4096, 16'h0000, 2'b00);
        chk("oor_rdata", 0, 32'(rdata[0]), 32'd0);
        access(0, 0, 1'b1, 1'b0, 0, 16'h0000, 2'b00);

        // Byte mask.
        access(0, 0, 1'b0, 1'b1, 2, 16'hFFFF, 2'b11);
        access(0, 0, 1'b0, 1'b1, 2, 16'h00AB, 2'b01);
        access(0, 1, 1'b1, 1'b0, 2, 16'h0000, 2'b00);
        chk("mask_readback", 0, 32'(rdata[0]), 32'(MASK_EXP));

        // Contention.
        rr(0, 8);
        rr(1, 4);

        // Wait-state read on dut1.
        access(1, 0, 1'b1, 1'b0, 5, 16'h0000, 2'b00);

        // Reset in the middle of a write on dut2.
        access(2, 0, 1'b0, 1'b1, 7, 16'h1111, 2'b11);
        access(2, 1, 1'b1, 1'b0, 7, 16'h0000, 2'b00);
        wr_en[2][0]      = 1'b1;
        addr[2][15:0]    = 16'd7;
        wdata[2][15:0]   = 16'h2222;
        wmask[2][1:0]    = 2'b11;
        @(posedge clk); #1;
        chk("abort_granted", 2, 32'(busy[2]), 32'd1);
        @(posedge clk); #2;
        rst_n[2] = 1'b0;
        #1;
        chk("abort_busy", 2, 32'(busy[2]), 32'd0);
        chk("abort_done", 2, 32'(done[2]), 32'd0);
        chk("abort_rdata", 2, 32'(rdata[2]), 32'd0);
        chk("abort_grant", 2, 32'(grant[2]), 32'd1);
        wr_en[2][0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_nodone", 2, 32'(done[2]), 32'd0);
        end
        rst_n[2]     = 1'b1;
        mdl_rdata[2] = 16'h0000;
        mdl_last[2]  = 1;
        @(posedge clk); #1;
        rr(2, 4);
        access(2, 0, 1'b1, 1'b0, 7, 16'h0000, 2'b00);
        chk("abort_keep", 2, 32'(rdata[2]), 32'h00001111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb_fsm.md
MEM_ARB_FSM -- requirements
Module: mem_arb_fsm

Interface
REQ-001 Parameters SHALL be, one per line, name, default, meaning:
  DATA_W  16  data word width, a multiple of 8;
  ADDR_W  16  address width;
  DEPTH  4096  implemented words, at most 2^ADDR_W;
  NUM_CH  2  requester channels, 1..8;
  WAIT_ST  0  extra wait cycles per access, 0..15.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rd_en  in  NUM_CH  per-channel read request, held until that channel's done.
REQ-005 wr_en  in  NUM_CH  per-channel write request, held until that channel's done.
REQ-006 addr  in  NUM_CH*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-007 wdata  in  NUM_CH*DATA_W  per-channel write data, packed like addr.
REQ-008 wmask  in  NUM_CH*DATA_W/8  per-channel byte write enables; only used under MEM_ARB_BYTE_MASK_EN.
REQ-009 rdata  out  DATA_W  read data of the last completed read.
REQ-010 done  out  NUM_CH  one-cycle completion pulse per channel.
REQ-011 err  out  1  completed access was out of range; valid while any done bit is high.
REQ-012 busy  out  1  high while an access is in progress, i.e. not IDLE.
REQ-013 grant  out  clog2(NUM_CH), minimum 1  index of the channel being served or last served.

Function
REQ-014 Internal storage SHALL be a DEPTH x DATA_W register array; contents SHALL NOT be reset.
REQ-015 States SHALL be IDLE, WAIT and COMPLETE, in that order.
  - IDLE->WAIT on grant when WAIT_ST>0.
  - IDLE->COMPLETE on grant when WAIT_ST=0.
  - WAIT->COMPLETE after WAIT_ST cycles.
  - COMPLETE->IDLE unconditionally.
REQ-016 A channel is eligible when its rd_en or wr_en is high and its done bit is low.
  - Rationale: a channel is not re-served in the cycle its done is high.
REQ-017 Arbitration SHALL be round-robin among eligible channels, starting at grant+1 modulo NUM_CH.
REQ-018 On grant, the block SHALL latch the channel, address, data, mask and operation; input changes after the grant edge SHALL NOT affect the access.
REQ-019 If both rd_en and wr_en are high on one channel, the access SHALL be a read.
REQ-020 Latency: with a grant at edge k, done[ch] SHALL be high for exactly the cycle after edge k+1+WAIT_ST.
REQ-021 The array write and the rdata update SHALL take effect at edge k+1+WAIT_ST.
REQ-022 rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
REQ-023 An address >= DEPTH SHALL be handled as follows:
  - a write SHALL be discarded;
  - a read SHALL return 0;
  - done SHALL still pulse, with err=1.
REQ-024 At most one done bit SHALL be high in any cycle.
REQ-025 The next grant SHALL occur no earlier than the IDLE cycle following COMPLETE.
  - Peak throughput: one access per 2+WAIT_ST cycles.

Reset
REQ-026 On rst_n low the block SHALL immediately, without waiting for clk, set:
  - state=IDLE;
  - done=0, err=0, busy=0, rdata=0;
  - grant=NUM_CH-1, so channel 0 wins first.
REQ-027 Reset asserted mid-access SHALL abort the access with no done pulse.
  - A write SHALL NOT reach the array unless its completion edge preceded reset.
REQ-028 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge after deassertion.

Configuration
REQ-029 The macro MEM_ARB_BYTE_MASK_EN SHALL control byte masking.
  - Defined: a write SHALL update only the bytes whose wmask bit is 1; an all-zero mask leaves the word unchanged but still completes with done.
  - Undefined: wmask SHALL be ignored and every write SHALL replace the full word.

Verification
REQ-030 Single write/read, WAIT_ST=0.
  - ch0 writes 0xBEEF to addr 5, then reads addr 5.
  - Required: done[0] one cycle after each grant; rdata=0xBEEF; err=0.
REQ-031 Round-robin contention, NUM_CH=2.
  - ch0 and ch1 both hold rd_en continuously.
  - Required: grants alternate 0,1,0,1; each done is one cycle wide; at most one done bit high.
REQ-032 Wait states, WAIT_ST=3.
  - A read is granted at edge k.
  - Required: done at the cycle after edge k+4; busy high over edges k+1..k+4.
REQ-033 Out of range, DEPTH=4096.
  - Write 0x1234 to 4096, then read 4096.
  - Required: err=1 with each done; rdata=0; addr 0 unchanged.
REQ-034 Byte mask.
  - Write 0xFFFF to addr 2, then write 0x00AB with wmask=01.
  - Required, macro defined: readback 0xFFAB.
  - Required, macro undefined: readback 0x00AB.
REQ-035 Reset mid-write, WAIT_ST=2.
  - Pull rst_n low one cycle after the write grant.
  - Required: no done pulse; location keeps its old value; busy=0 immediately.
